download_scheduler: RTL and testbench
=====================================

DOWNLOAD_SCHEDULER -- requirements
Module: download_scheduler

Interface
REQ-001 Parameter MAX_STALL, default 255: sink-stall cycles tolerated before abort; range 1..255.
REQ-002 Parameter BYTE_W, default 8: download byte width.
REQ-003 clock  in  1  single system clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 download_en  in  1  user download request, already synchronized.
REQ-006 req  in  2  per-camera ready-to-download (camera idle, buffer holds data); bit0 = cam1, bit1 = cam2.
REQ-007 level0, level1  in  4 each  buffer fill in tenths, 0..10.
REQ-008 byte0, byte1  in  BYTE_W each  current head byte of each buffer.
REQ-009 sink_ready  in  1  microcontroller accepts out_byte this cycle.
REQ-010 grant  out  2  one-hot owner of the download channel; 00 when free.
REQ-011 pop  out  2  one-cycle pulse advancing the owning buffer by one byte.
REQ-012 out_byte  out  BYTE_W  registered byte to sink.
REQ-013 out_valid  out  1  out_byte valid.
REQ-014 done  out  2  one-cycle pulse: owning camera fully drained.
REQ-015 abort_err  out  1  sticky: a transfer was aborted; cleared by the next granted transfer.
REQ-016 beat_count  out  8  bytes sent in current/last transfer; saturates at 255.

Function
REQ-017 FSM states IDLE, LOAD, SEND, SETTLE, FINISH; one state per cycle except SEND, which holds while stalled.
REQ-018 IDLE: when download_en=1 and req!=00, grant the selected camera, clear beat_count and abort_err, go to LOAD.
REQ-019 Arbitration round-robin: single requester wins; both requesting -> camera not served last; after reset cam1 has priority.
REQ-020 Grant at level 0 -> go directly to FINISH (zero-length transfer, done pulse, no pop).
REQ-021 LOAD: capture the granted camera's byte into out_byte; go to SEND.
REQ-022 SEND: out_valid=1; on sink_ready=1, pulse pop for the owner in that cycle, increment beat_count, go to SETTLE.
REQ-023 SETTLE: one-cycle wait for buffer level update; level=0 -> FINISH; owner's req=0 or download_en=0 -> abort; otherwise -> LOAD.
REQ-024 FINISH: pulse done for owner, record owner as last-served, release grant, go to IDLE.
REQ-025 Stall: sink_ready=0 in SEND for MAX_STALL consecutive cycles -> abort; stall counter clears on each accepted byte.
REQ-026 Abort: drop out_valid, release grant, set abort_err, no done pulse, record owner as last-served, go to IDLE.
REQ-027 download_en or req deasserted during SEND never truncates the byte on offer; it takes effect in SETTLE.
REQ-028 Non-owner req changes during a transfer are ignored until IDLE.
REQ-029 Invariants: at most one grant bit high; pop only to the granted camera; pop and out_valid never high in IDLE.
REQ-030 out_byte holds its value outside LOAD.

Reset
REQ-031 reset low asynchronously forces IDLE, grant=00, pop=00, done=00, out_valid=0, out_byte=0, beat_count=0, abort_err=0, stall counter=0, last-served=cam2.
REQ-032 reset asserted mid-transfer drops the grant immediately and issues no pop or done; a fresh arbitration follows release.

Structure
REQ-033 Shared package holds the FSM state enum, camera index constants (CAM1=0, CAM2=1), and LEVEL_FULL=10.
REQ-034 Round-robin picker is one sub-module, rr_arbiter2 (req, last-served in; one-hot grant out; combinational).

Verification
REQ-035 Reset, download_en=1, req=01, level0=3, sink_ready=1, buffer model decrements level on pop -> 3 pops, 3 bytes in order, done=01, beat_count=3.
REQ-036 req=11, both levels 2, two consecutive downloads -> cam1 served first, then cam2; grant never 11.
REQ-037 sink_ready held 0 with MAX_STALL=4 -> abort after 4 SEND cycles, abort_err=1, grant=00, no done, no pop.
REQ-038 download_en dropped during SEND of byte 2 of 5 -> byte 2 completes with pop, abort in SETTLE, beat_count=2.
REQ-039 req=01, level0=0 -> done=01 within 2 cycles of grant, zero pops, beat_count=0.
REQ-040 reset pulsed low mid-SEND -> all outputs zero asynchronously; next transfer grants cam1 first.

Source files
------------

// File: rtl/download_scheduler_pkg.sv
// Shared types and constants for the camera download scheduler.
// Imported by the arbiter and the scheduler top.
package download_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_SETTLE,
    S_FINISH
  } state_t;

  localparam logic CAM1 = 1'b0;
  localparam logic CAM2 = 1'b1;

  localparam logic [3:0] LEVEL_FULL = 4'd10;

endpackage

// File: rtl/download_scheduler_arb.sv
// Two-way round-robin picker for the download channel.
// Combinational: ties go to the camera not served last.
module rr_arbiter2
  import download_scheduler_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (i_last == CAM1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/download_scheduler.sv
// Moves buffered camera bytes to the microcontroller one at a time,
// with round-robin ownership, stall abort and sticky error reporting.
module download_scheduler
  import download_scheduler_pkg::*;
#(
  parameter int MAX_STALL = 255,
  parameter int BYTE_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_download_en,
  input  logic [1:0]        i_req,
  input  logic [3:0]        i_level0,
  input  logic [3:0]        i_level1,
  input  logic [BYTE_W-1:0] i_byte0,
  input  logic [BYTE_W-1:0] i_byte1,
  input  logic              i_sink_ready,
  output logic [1:0]        o_grant,
  output logic [1:0]        o_pop,
  output logic [BYTE_W-1:0] o_out_byte,
  output logic              o_out_valid,
  output logic [1:0]        o_done,
  output logic              o_abort_err,
  output logic [7:0]        o_beat_count
);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_grant;
  logic              r_last;
  logic [BYTE_W-1:0] r_out_byte;
  logic [7:0]        r_beat;
  logic              r_abort;
  logic [7:0]        r_stall;

  logic [1:0]        w_arb;
  logic              w_own;
  logic [3:0]        w_sel_level;
  logic [3:0]        w_own_level;
  logic              w_own_req;
  logic [BYTE_W-1:0] w_own_byte;
  logic              w_stall_hit;
  logic              w_take;
  logic              w_accept;
  logic              w_finish;
  logic              w_abort;

  rr_arbiter2 u_arb (
    .i_req  (i_req),
    .i_last (r_last),
    .o_gnt  (w_arb)
  );

  assign w_own       = r_grant[1] ? CAM2 : CAM1;
  assign w_sel_level = w_arb[1] ? i_level1 : i_level0;
  assign w_own_level = w_own ? i_level1 : i_level0;
  assign w_own_req   = i_req[w_own];
  assign w_own_byte  = w_own ? i_byte1 : i_byte0;
  assign w_stall_hit = (r_stall == 8'(MAX_STALL - 1));

  always_comb begin
    w_next   = r_state;
    w_take   = 1'b0;
    w_accept = 1'b0;
    w_finish = 1'b0;
    w_abort  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_download_en && (i_req != 2'b00)) begin
          w_take = 1'b1;
          w_next = (w_sel_level == 4'd0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: w_next = S_SEND;
      S_SEND: begin
        if (i_sink_ready) begin
          w_accept = 1'b1;
          w_next   = S_SETTLE;
        end else if (w_stall_hit) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_SETTLE: begin
        // Level is re-read here, one cycle after the pop landed.
        if (w_own_level == 4'd0) begin
          w_next = S_FINISH;
        end else if (!w_own_req || !i_download_en) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_next = S_LOAD;
        end
      end
      S_FINISH: begin
        w_finish = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= 2'b00;
      r_last     <= CAM2;
      r_out_byte <= '0;
      r_beat     <= 8'd0;
      r_abort    <= 1'b0;
      r_stall    <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_grant <= w_arb;
        r_beat  <= 8'd0;
        r_abort <= 1'b0;
        r_stall <= 8'd0;
      end
      if (r_state == S_LOAD) begin
        r_out_byte <= w_own_byte;
      end
      if (r_state == S_SEND) begin
        r_stall <= i_sink_ready ? 8'd0 : r_stall + 8'd1;
      end
      if (w_accept && (r_beat != 8'hFF)) begin
        r_beat <= r_beat + 8'd1;
      end
      if (w_abort || w_finish) begin
        r_grant <= 2'b00;
        r_last  <= w_own;
        r_stall <= 8'd0;
      end
      if (w_abort) begin
        r_abort <= 1'b1;
      end
    end
  end

  assign o_grant      = r_grant;
  assign o_pop        = w_accept ? r_grant : 2'b00;
  assign o_out_byte   = r_out_byte;
  assign o_out_valid  = (r_state == S_SEND);
  assign o_done       = w_finish ? r_grant : 2'b00;
  assign o_abort_err  = r_abort;
  assign o_beat_count = r_beat;

endmodule

// File: tb/tb_download_scheduler.sv
// Directed bench for download_scheduler with a small
// two-buffer camera model driven from the pop pulses.
module tb_download_scheduler;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] req;
  logic [3:0] lvl0;
  logic [3:0] lvl1;
  logic [7:0] byte0;
  logic [7:0] byte1;
  logic       sr;
  logic [1:0] grant;
  logic [1:0] pop;
  logic [7:0] ob;
  logic       ov;
  logic [1:0] done;
  logic       aerr;
  logic [7:0] beat;

  logic [7:0] buf0 [8];
  logic [7:0] buf1 [8];
  int         idx0;
  int         idx1;

  int n_cmp;
  int n_bad;

  int         n_pop;
  int         n_valid;
  int         pop_bad;
  int         viol;
  int         tmo;
  int         g_cyc;
  int         d_cyc;
  logic [1:0] done_acc;
  logic [1:0] first_g;
  logic [7:0] got [$];

  assign byte0 = buf0[idx0[2:0]];
  assign byte1 = buf1[idx1[2:0]];

  download_scheduler #(
    .MAX_STALL (4),
    .BYTE_W    (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_download_en (en),
    .i_req         (req),
    .i_level0      (lvl0),
    .i_level1      (lvl1),
    .i_byte0       (byte0),
    .i_byte1       (byte1),
    .i_sink_ready  (sr),
    .o_grant       (grant),
    .o_pop         (pop),
    .o_out_byte    (ob),
    .o_out_valid   (ov),
    .o_done        (done),
    .o_abort_err   (aerr),
    .o_beat_count  (beat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 2'b00;
    sr    = 1'b0;
    idx0  = 0;
    idx1  = 0;
    lvl0  = 4'd0;
    lvl1  = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one transfer; drop_at>0 deasserts en in the SEND of that byte.
  task automatic run_xfer(input int maxc, input int drop_at);
    bit seen;
    seen     = 0;
    n_pop    = 0;
    n_valid  = 0;
    pop_bad  = 0;
    tmo      = 1;
    g_cyc    = -1;
    d_cyc    = -1;
    done_acc = 2'b00;
    first_g  = 2'b00;
    got.delete();
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (grant == 2'b11) viol++;
      if (ov) n_valid++;
      if (ov && drop_at > 0 && n_pop == drop_at - 1) en = 1'b0;
      if (pop != 2'b00 && (pop & ~grant) != 2'b00) pop_bad++;
      if (pop[0]) begin
        got.push_back(ob);
        n_pop++;
        lvl0 = lvl0 - 4'd1;
        idx0++;
      end
      if (pop[1]) begin
        got.push_back(ob);
        n_pop++;
        lvl1 = lvl1 - 4'd1;
        idx1++;
      end
      if (done != 2'b00) begin
        done_acc = done_acc | done;
        if (d_cyc < 0) d_cyc = c;
      end
      if (grant != 2'b00 && !seen) begin
        seen    = 1;
        first_g = grant;
        g_cyc   = c;
      end
      if (seen && grant == 2'b00) begin
        en  = 1'b0;
        tmo = 0;
        break;
      end
    end
    en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    viol  = 0;
    buf0[0] = 8'hA1; buf0[1] = 8'hB2; buf0[2] = 8'hC3;
    buf0[3] = 8'hD4; buf0[4] = 8'hE5; buf0[5] = 8'hF6;
    buf0[6] = 8'h17; buf0[7] = 8'h28;
    buf1[0] = 8'h51; buf1[1] = 8'h62; buf1[2] = 8'h73;
    buf1[3] = 8'h84; buf1[4] = 8'h95; buf1[5] = 8'hA6;
    buf1[6] = 8'hB7; buf1[7] = 8'hC8;

    do_reset();
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(ov), 0);
    chk("rst_byte", 32'(ob), 0);
    chk("rst_beat", 32'(beat), 0);
    chk("rst_aerr", 32'(aerr), 0);

    // Three-byte cam1 drain
    @(negedge clk);
    lvl0 = 4'd3; req = 2'b01; sr = 1'b1; en = 1'b1;
    run_xfer(60, 0);
    chk("t1_tmo", 32'(tmo), 0);
    chk("t1_pops", 32'(n_pop), 3);
    chk("t1_b0", 32'(got.size() > 0 ? got[0] : 8'h00), 32'hA1);
    chk("t1_b1", 32'(got.size() > 1 ? got[1] : 8'h00), 32'hB2);
    chk("t1_b2", 32'(got.size() > 2 ? got[2] : 8'h00), 32'hC3);
    chk("t1_done", 32'(done_acc), 32'h1);
    chk("t1_beat", 32'(beat), 3);
    chk("t1_hold", 32'(ob), 32'hC3);
    chk("t1_aerr", 32'(aerr), 0);
    chk("t1_popbad", 32'(pop_bad), 0);

    // Round robin with both cameras ready
    do_reset();
    @(negedge clk);
    lvl0 = 4'd2; lvl1 = 4'd2; req = 2'b11; sr = 1'b1; en = 1'b1;
    run_xfer(60, 0);
    chk("t2a_grant", 32'(first_g), 32'h1);
    chk("t2a_done", 32'(done_acc), 32'h1);
    chk("t2a_pops", 32'(n_pop), 2);
    lvl0 = 4'd2;
    idx0 = 0;
    @(negedge clk);
    en = 1'b1;
    run_xfer(60, 0);
    chk("t2b_grant", 32'(first_g), 32'h2);
    chk("t2b_done", 32'(done_acc), 32'h2);
    chk("t2b_b0", 32'(got.size() > 0 ? got[0] : 8'h00), 32'h51);
    chk("t2b_b1", 32'(got.size() > 1 ? got[1] : 8'h00), 32'h62);
    chk("t2_viol", 32'(viol), 0);

    // Sink stalls until abort
    do_reset();
    @(negedge clk);
    lvl0 = 4'd3; req = 2'b01; sr = 1'b0; en = 1'b1;
    run_xfer(60, 0);
    chk("t3_tmo", 32'(tmo), 0);
    chk("t3_sends", 32'(n_valid), 4);
    chk("t3_aerr", 32'(aerr), 1);
    chk("t3_grant", 32'(grant), 0);
    chk("t3_done", 32'(done_acc), 0);
    chk("t3_pops", 32'(n_pop), 0);

    // Enable dropped while byte 2 of 5 is on offer
    do_reset();
    @(negedge clk);
    lvl0 = 4'd5; req = 2'b01; sr = 1'b1; en = 1'b1;
    run_xfer(60, 2);
    chk("t4_pops", 32'(n_pop), 2);
    chk("t4_beat", 32'(beat), 2);
    chk("t4_aerr", 32'(aerr), 1);
    chk("t4_done", 32'(done_acc), 0);
    chk("t4_b1", 32'(got.size() > 1 ? got[1] : 8'h00), 32'hB2);

    // Zero-length grant; also clears the sticky error
    @(negedge clk);
    lvl0 = 4'd0; req = 2'b01; sr = 1'b1; en = 1'b1;
    run_xfer(30, 0);
    chk("t5_done", 32'(done_acc), 32'h1);
    chk("t5_lat", 32'((d_cyc >= 0) && (d_cyc - g_cyc <= 1)), 1);
    chk("t5_pops", 32'(n_pop), 0);
    chk("t5_beat", 32'(beat), 0);
    chk("t5_aerr", 32'(aerr), 0);

    // Reset mid-SEND on cam2 restores cam1 priority
    do_reset();
    @(negedge clk);
    idx0 = 0;
    lvl0 = 4'd1; req = 2'b01; sr = 1'b1; en = 1'b1;
    run_xfer(30, 0);
    lvl0 = 4'd2; lvl1 = 4'd2; idx1 = 0;
    req = 2'b11; sr = 1'b0; en = 1'b1;
    tmo = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ov) begin
        tmo = 0;
        break;
      end
    end
    chk("t6_tmo", 32'(tmo), 0);
    chk("t6_own", 32'(grant), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_grant", 32'(grant), 0);
    chk("t6_pop", 32'(pop), 0);
    chk("t6_valid", 32'(ov), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_byte", 32'(ob), 0);
    chk("t6_beat", 32'(beat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sr = 1'b1; en = 1'b1;
    run_xfer(60, 0);
    chk("t6_first", 32'(first_g), 32'h1);
    chk("t6_fdone", 32'(done_acc), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
